fetch_packet_queue: RTL and testbench

//  Decoupling FIFO directly downstream of the L1 instruction cache response port.

---
 rtl/fetch_packet_queue.sv | 105 ++++++++++
 tb/tb_fetch_packet_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_packet_queue.sv
// fetch_packet_queue: first-word-fall-through FIFO of 4-wide fetch packets that
// sits between the icache response port and decode. Packets with no valid
// slots are accepted but not stored. A flush empties the queue in one cycle.
module fetch_packet_queue #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        io_in_valid,
  output logic                        io_in_ready,
  input  logic [31:0]                 io_in_bits_fetch_PC,
  input  logic [FETCH_WIDTH-1:0]      io_in_bits_valid_bits,
  input  logic [32*FETCH_WIDTH-1:0]   io_in_bits_instructions,
  input  logic                        io_in_bits_pred_hit,
  input  logic [31:0]                 io_in_bits_pred_target,
  input  logic [15:0]                 io_in_bits_GHR,
  output logic                        io_out_valid,
  input  logic                        io_out_ready,
  output logic [31:0]                 io_out_bits_fetch_PC,
  output logic [FETCH_WIDTH-1:0]      io_out_bits_valid_bits,
  output logic [32*FETCH_WIDTH-1:0]   io_out_bits_instructions,
  output logic                        io_out_bits_pred_hit,
  output logic [31:0]                 io_out_bits_pred_target,
  output logic [15:0]                 io_out_bits_GHR,
  input  logic                        io_flush_valid,
  output logic [$clog2(DEPTH):0]      io_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 32 + FETCH_WIDTH + 32 * FETCH_WIDTH + 1 + 32 + 16;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Packet storage; deliberately not reset, validity comes from the pointers.
  logic [EW-1:0] mem_r [DEPTH];

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;

  logic          empty_s;
  logic          full_s;
  logic          enq_fire_s;
  logic          enq_store_s;
  logic          deq_fire_s;
  logic [EW-1:0] in_pkt_s;
  logic [EW-1:0] out_pkt_s;

  assign empty_s = (head_r == tail_r);
  assign full_s  = (head_r[AW-1:0] == tail_r[AW-1:0]) && (head_r[PW-1] != tail_r[PW-1]);

  // Ready depends only on registered state; a same-cycle dequeue does not free a slot.
  assign io_in_ready  = ~full_s;
  assign io_out_valid = ~empty_s;

  assign enq_fire_s  = io_in_valid & io_in_ready & ~io_flush_valid;
  assign enq_store_s = enq_fire_s & (|io_in_bits_valid_bits);
  assign deq_fire_s  = io_out_valid & io_out_ready;

  assign in_pkt_s = {io_in_bits_fetch_PC, io_in_bits_valid_bits, io_in_bits_instructions,
                     io_in_bits_pred_hit, io_in_bits_pred_target, io_in_bits_GHR};

  // Occupancy as a pointer difference stays correct across wrap.
  assign io_count = tail_r - head_r;

  // Pointer update: flush wins over enqueue and dequeue in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_r <= {PW{1'b0}};
      tail_r <= {PW{1'b0}};
    end else if (io_flush_valid) begin
      head_r <= {PW{1'b0}};
      tail_r <= {PW{1'b0}};
    end else begin
      if (enq_store_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (deq_fire_s) begin
        head_r <= head_r + PTR_ONE;
      end
    end
  end

  // Write accepted non-empty packets at the tail slot.
  always_ff @(posedge clock) begin
    if (enq_store_s) begin
      mem_r[tail_r[AW-1:0]] <= in_pkt_s;
    end
  end

  // Head packet falls through to decode; zero when the queue is empty.
  always_comb begin
    out_pkt_s = {EW{1'b0}};
    if (!empty_s) begin
      out_pkt_s = mem_r[head_r[AW-1:0]];
    end else begin
      out_pkt_s = {EW{1'b0}};
    end
  end

  assign {io_out_bits_fetch_PC, io_out_bits_valid_bits, io_out_bits_instructions,
          io_out_bits_pred_hit, io_out_bits_pred_target, io_out_bits_GHR} = out_pkt_s;

endmodule

// File: tb/tb_fetch_packet_queue.sv
// Testbench for fetch_packet_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model by a separate monitor process.
module tb_fetch_packet_queue;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0]  pc;
    logic [3:0]   vb;
    logic [127:0] insts;
    logic         hit;
    logic [31:0]  tgt;
    logic [15:0]  ghr;
  } pkt_t;

  logic         clock;
  logic         reset;
  logic         io_in_valid;
  logic         io_in_ready;
  pkt_t         in_pkt;
  logic         io_out_valid;
  logic         io_out_ready;
  logic [31:0]  out_pc;
  logic [3:0]   out_vb;
  logic [127:0] out_insts;
  logic         out_hit;
  logic [31:0]  out_tgt;
  logic [15:0]  out_ghr;
  logic         io_flush_valid;
  logic [3:0]   io_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: packets that are stored and not yet consumed, oldest first.
  pkt_t exp_q[$];

  fetch_packet_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(4)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .io_in_valid              (io_in_valid),
    .io_in_ready              (io_in_ready),
    .io_in_bits_fetch_PC      (in_pkt.pc),
    .io_in_bits_valid_bits    (in_pkt.vb),
    .io_in_bits_instructions  (in_pkt.insts),
    .io_in_bits_pred_hit      (in_pkt.hit),
    .io_in_bits_pred_target   (in_pkt.tgt),
    .io_in_bits_GHR           (in_pkt.ghr),
    .io_out_valid             (io_out_valid),
    .io_out_ready             (io_out_ready),
    .io_out_bits_fetch_PC     (out_pc),
    .io_out_bits_valid_bits   (out_vb),
    .io_out_bits_instructions (out_insts),
    .io_out_bits_pred_hit     (out_hit),
    .io_out_bits_pred_target  (out_tgt),
    .io_out_bits_GHR          (out_ghr),
    .io_flush_valid           (io_flush_valid),
    .io_count                 (io_count)
  );

  // 10-unit clock period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pkt_t mk_pkt(input logic [31:0] pc, input logic [3:0] vb);
    pkt_t p;
    p.pc    = pc;
    p.vb    = vb;
    p.insts = {$urandom, $urandom, $urandom, $urandom};
    p.hit   = 1'($urandom);
    p.tgt   = $urandom;
    p.ghr   = 16'($urandom);
    return p;
  endfunction

  function automatic pkt_t dut_pkt();
    pkt_t p;
    p.pc    = out_pc;
    p.vb    = out_vb;
    p.insts = out_insts;
    p.hit   = out_hit;
    p.tgt   = out_tgt;
    p.ghr   = out_ghr;
    return p;
  endfunction

  // Monitor: compares the presented head against the model and consumes on handshake.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        chk("out_valid", 256'(io_out_valid), 256'(exp_q.size() != 0));
        if (io_out_valid && exp_q.size() > 0) begin
          chk("head_pkt", 256'(dut_pkt()), 256'(exp_q[0]));
          if (io_out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One bus cycle: drive, check occupancy/ready, then update the model after the edge.
  task automatic step(input logic iv, input pkt_t p, input logic ordy, input logic fl);
    logic accept;
    @(negedge clock);
    io_in_valid    = iv;
    in_pkt         = p;
    io_out_ready   = ordy;
    io_flush_valid = fl;
    #1;
    chk("in_ready", 256'(io_in_ready), 256'(exp_q.size() < DEPTH));
    chk("count", 256'(io_count), 256'(exp_q.size()));
    accept = iv && (exp_q.size() < DEPTH) && !fl;
    @(posedge clock);
    #1;
    if (fl) exp_q.delete();
    else if (accept && p.vb != 4'b0000) exp_q.push_back(p);
  endtask

  task automatic idle();
    step(1'b0, mk_pkt(32'h0, 4'hF), 1'b0, 1'b0);
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] vb;
      vb = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      step(1'($urandom_range(0, 3) != 0), mk_pkt($urandom & 32'hFFFF_FFF0, vb),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end
  endtask

  initial begin
    reset          = 1'b0;
    io_in_valid    = 1'b0;
    in_pkt         = '0;
    io_out_ready   = 1'b0;
    io_flush_valid = 1'b0;
    #3;
    // Reset state
    chk("rst_count", 256'(io_count), 256'(0));
    chk("rst_out_valid", 256'(io_out_valid), 256'(0));
    chk("rst_in_ready", 256'(io_in_ready), 256'(1));
    chk("rst_out_pc", 256'(out_pc), 256'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // 1. Fill with 8 packets, then offer a 9th that must stall
    for (int i = 0; i < 8; i++) step(1'b1, mk_pkt(32'h1000 + 32'(i) * 32'h10, 4'hF), 1'b0, 1'b0);
    step(1'b1, mk_pkt(32'h1080, 4'hF), 1'b0, 1'b0);
    chk("full_count", 256'(io_count), 256'(8));
    chk("full_in_ready", 256'(io_in_ready), 256'(0));

    // 2. Drain in order
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_pc", 256'(out_pc), 256'(32'h1000 + 32'(i) * 32'h10));
      step(1'b0, mk_pkt(32'h0, 4'hF), 1'b1, 1'b0);
    end
    #1;
    chk("drained_valid", 256'(io_out_valid), 256'(0));
    chk("drained_count", 256'(io_count), 256'(0));
    // The stalled 9th packet is re-offered and delivered
    step(1'b1, mk_pkt(32'h1080, 4'hF), 1'b0, 1'b0);
    #1;
    chk("ninth_pc", 256'(out_pc), 256'(32'h1080));

    // 3. Simultaneous enqueue and dequeue at count 1
    step(1'b1, mk_pkt(32'h2000, 4'h3), 1'b1, 1'b0);
    #1;
    chk("simul_count", 256'(io_count), 256'(1));
    chk("simul_pc", 256'(out_pc), 256'(32'h2000));

    // 4. Flush at count 5 together with an enqueue of 0x3000
    for (int i = 0; i < 4; i++) step(1'b1, mk_pkt(32'h2100 + 32'(i) * 32'h10, 4'hF), 1'b0, 1'b0);
    step(1'b1, mk_pkt(32'h3000, 4'hF), 1'b0, 1'b1);
    #1;
    chk("flush_count", 256'(io_count), 256'(0));
    chk("flush_valid", 256'(io_out_valid), 256'(0));
    idle();
    chk("flush_no_3000", 256'(io_out_valid), 256'(0));

    // 5. Empty packet is accepted but never stored
    step(1'b1, mk_pkt(32'h4000, 4'b0000), 1'b0, 1'b0);
    #1;
    chk("empty_pkt_count", 256'(io_count), 256'(0));
    chk("empty_pkt_valid", 256'(io_out_valid), 256'(0));

    // 6. Random traffic across pointer wrap, with a mid-stream reset
    for (int i = 0; i < 6; i++) step(1'b1, mk_pkt(32'h5000 + 32'(i) * 32'h10, 4'hF), 1'b0, 1'b0);
    rand_steps(20);
    @(negedge clock);
    io_in_valid    = 1'b0;
    io_out_ready   = 1'b0;
    io_flush_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_count", 256'(io_count), 256'(0));
    chk("midrst_out_valid", 256'(io_out_valid), 256'(0));
    chk("midrst_in_ready", 256'(io_in_ready), 256'(1));
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    rand_steps(20);
    for (int i = 0; i < 10; i++) step(1'b0, mk_pkt(32'h0, 4'hF), 1'b1, 1'b0);
    #1;
    chk("final_count", 256'(io_count), 256'(exp_q.size()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
